// File: rtl/dat_chunk_comb.sv
// Compressed IFM data chunk buffer: stores the chunk sparsemap and compacts nonzero bytes into a 1-based dense array.
// Optional DAT_CHUNK_CLR_EN: a beat with wr_count_i==0 also clears stale map bits and data entries above the new fill.
module dat_chunk_comb #(
    parameter  int unsigned MEM_SIZE   = 128,
    parameter  int unsigned BUS_SIZE   = 16,
    localparam int unsigned WR_CYC_NUM = MEM_SIZE / BUS_SIZE,
    localparam int unsigned CNT_W      = (WR_CYC_NUM > 1) ? $clog2(WR_CYC_NUM) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [BUS_SIZE-1:0]            wr_sparsemap_i,
    input  logic [BUS_SIZE-1:0][7:0]       wr_nonzero_data_i,
    input  logic                           wr_valid_i,
    input  logic [CNT_W-1:0]               wr_count_i,
    output logic [MEM_SIZE:1][7:0]         rd_nonzero_data_o,
    output logic [MEM_SIZE-1:0]            rd_sparsemap_o
);

    localparam int unsigned FP_W = $clog2(MEM_SIZE) + 1;

    logic [MEM_SIZE-1:0]    map_q, map_d;
    logic [MEM_SIZE:1][7:0] data_q, data_d;
    logic [FP_W-1:0]        fp_q, fp_d;

    logic [FP_W-1:0]        base;
    logic [FP_W-1:0]        fill_next;
    logic [FP_W-1:0]        dst [BUS_SIZE];

    // Destination slot of each lane: base + 1 + rank of the lane among the set map bits.
    always_comb begin
        logic [FP_W-1:0] run;
        base = (wr_count_i == '0) ? '0 : fp_q;
        run  = base;
        for (int k = 0; k < BUS_SIZE; k++) begin
            dst[k] = run + FP_W'(1);
            if (wr_sparsemap_i[k]) begin
                run = run + FP_W'(1);
            end
        end
        fill_next = run;
    end

    always_comb begin
        map_d  = map_q;
        data_d = data_q;
        fp_d   = fp_q;
        if (wr_valid_i) begin
`ifdef DAT_CHUNK_CLR_EN
            if (wr_count_i == '0) begin
                for (int b = BUS_SIZE; b < MEM_SIZE; b++) begin
                    map_d[b] = 1'b0;
                end
                for (int i = 1; i <= MEM_SIZE; i++) begin
                    if (FP_W'(i) > fill_next) begin
                        data_d[i] = '0;
                    end
                end
            end
`endif
            for (int c = 0; c < WR_CYC_NUM; c++) begin
                if (wr_count_i == CNT_W'(c)) begin
                    for (int k = 0; k < BUS_SIZE; k++) begin
                        map_d[c*BUS_SIZE + k] = wr_sparsemap_i[k];
                    end
                end
            end
            // Each slot picks the lane whose rank lands on it; at most one lane can match.
            for (int i = 1; i <= MEM_SIZE; i++) begin
                for (int k = 0; k < BUS_SIZE; k++) begin
                    if (wr_sparsemap_i[k] && (dst[k] == FP_W'(i))) begin
                        data_d[i] = wr_nonzero_data_i[k];
                    end
                end
            end
            fp_d = fill_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            map_q  <= '0;
            data_q <= '0;
            fp_q   <= '0;
        end else begin
            map_q  <= map_d;
            data_q <= data_d;
            fp_q   <= fp_d;
        end
    end

    assign rd_nonzero_data_o = data_q;
    assign rd_sparsemap_o    = map_q;

endmodule

// File: tb/tb_dat_chunk_comb.sv
// Scoreboard bench for dat_chunk_comb: directed scenarios plus random chunks against a byte-array model.
module tb_dat_chunk_comb;

    localparam int MEM = 128;
    localparam int BUS = 16;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [BUS-1:0]       wr_map;
    logic [BUS-1:0][7:0]  wr_data;
    logic                 wr_valid;
    logic [2:0]           wr_cnt;
    logic [MEM:1][7:0]    rd_data;
    logic [MEM-1:0]       rd_map;

    always #5 clk = ~clk;

    dat_chunk_comb dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .wr_sparsemap_i    (wr_map),
        .wr_nonzero_data_i (wr_data),
        .wr_valid_i        (wr_valid),
        .wr_count_i        (wr_cnt),
        .rd_nonzero_data_o (rd_data),
        .rd_sparsemap_o    (rd_map)
    );

    typedef struct {
        logic [MEM-1:0]    map;
        logic [MEM:1][7:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;

    // Reference state: plain byte array and fill count.
    logic [7:0]      m_data [1:MEM];
    logic [MEM-1:0]  m_map;
    int              m_fp;

    function automatic logic [BUS-1:0][7:0] rnd_lanes();
        logic [BUS-1:0][7:0] l;
        for (int k = 0; k < BUS; k++) l[k] = 8'($urandom);
        return l;
    endfunction

    function automatic logic [BUS-1:0] rnd_map();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return BUS'($urandom) & BUS'($urandom);
            default: return BUS'($urandom);
        endcase
    endfunction

    task automatic apply(input logic rst, input logic vld, input int cnt,
                         input logic [BUS-1:0] map, input logic [BUS-1:0][7:0] lanes);
        exp_t e;
        int   base, j, pop;
        @(negedge clk);
        rst_i    = rst;
        wr_valid = vld;
        wr_cnt   = 3'(cnt);
        wr_map   = map;
        wr_data  = lanes;
        if (!rst) begin
            m_map = '0;
            for (int i = 1; i <= MEM; i++) m_data[i] = 8'h00;
            m_fp = 0;
        end else if (vld) begin
            base = (cnt == 0) ? 0 : m_fp;
            pop  = $countones(map);
`ifdef DAT_CHUNK_CLR_EN
            if (cnt == 0) begin
                for (int b = BUS; b < MEM; b++) m_map[b] = 1'b0;
                for (int i = pop + 1; i <= MEM; i++) m_data[i] = 8'h00;
            end
`endif
            for (int k = 0; k < BUS; k++) m_map[cnt*BUS + k] = map[k];
            j = 0;
            for (int k = 0; k < BUS; k++) begin
                if (map[k]) begin
                    m_data[base + 1 + j] = lanes[k];
                    j++;
                end
            end
            m_fp = base + pop;
        end
        e.map = m_map;
        for (int i = 1; i <= MEM; i++) e.data[i] = m_data[i];
        sb_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [MEM:1][7:0] exp);
        int idx;
        n_vec++;
        if (rd_data !== exp) begin
            n_err++;
            idx = 0;
            for (int i = MEM; i >= 1; i--) if (rd_data[i] !== exp[i]) idx = i;
            $display("FAIL %s: data[%0d] got %h expected %h", name, idx, rd_data[idx], exp[idx]);
        end
    endtask

    // Monitor: every clock after the edge, the registered outputs must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_vec++;
            if (rd_map !== mon_e.map) begin
                n_err++;
                $display("FAIL sb_map @%0t: got %h expected %h", $time, rd_map, mon_e.map);
            end
            n_vec++;
            if (rd_data !== mon_e.data) begin
                n_err++;
                for (int i = 1; i <= MEM; i++) begin
                    if (rd_data[i] !== mon_e.data[i]) begin
                        $display("FAIL sb_data @%0t: data[%0d] got %h expected %h",
                                 $time, i, rd_data[i], mon_e.data[i]);
                        break;
                    end
                end
            end
        end
    end

    initial begin
        logic [BUS-1:0][7:0] lanes;
        logic [MEM:1][7:0]   exp_vec;
        logic [7:0]          b1, b2, b3, x;
        int                  guard;

        rst_i = 1'b0; wr_valid = 1'b0; wr_map = '0; wr_data = '0; wr_cnt = '0;
        m_map = '0; m_fp = 0;
        for (int i = 1; i <= MEM; i++) m_data[i] = 8'h00;

        // Reset for two clocks; the second one also carries a write that must lose.
        apply(1'b0, 1'b0, 0, '0, rnd_lanes());
        apply(1'b0, 1'b1, 0, '1, rnd_lanes());
        settle();
        chk("reset_map", 128'(rd_map), '0);
        chk_data("reset_data", '0);

        lanes = rnd_lanes(); lanes[0] = 8'hAA; lanes[1] = 8'h77; lanes[2] = 8'hBB;
        apply(1'b1, 1'b1, 0, 16'h0005, lanes);
        settle();
        chk("beat0_d1", 128'(rd_data[1]), 128'h0AA);
        chk("beat0_d2", 128'(rd_data[2]), 128'h0BB);
        chk("beat0_map", 128'(rd_map[15:0]), 128'h0005);

        lanes = rnd_lanes(); lanes[15] = 8'hCC;
        apply(1'b1, 1'b1, 1, 16'h8000, lanes);
        settle();
        chk("beat1_d3", 128'(rd_data[3]), 128'h0CC);
        chk("beat1_d12", 128'({rd_data[2], rd_data[1]}), 128'hBBAA);
        chk("beat1_map", 128'(rd_map[31:16]), 128'h8000);

        b1 = rd_data[1]; b2 = rd_data[2]; b3 = rd_data[3];
        for (int n = 0; n < 5; n++) apply(1'b1, 1'b0, $urandom_range(0, 7), rnd_map(), rnd_lanes());
        settle();
        chk("idle_d123", 128'({rd_data[3], rd_data[2], rd_data[1]}), 128'hCCBBAA);
        chk("idle_map", 128'(rd_map[31:0]), 128'h8000_0005);

        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < BUS; k++) lanes[k] = 8'(c*16 + k);
            apply(1'b1, 1'b1, c, 16'hFFFF, lanes);
        end
        settle();
        for (int i = 1; i <= MEM; i++) exp_vec[i] = 8'(i - 1);
        chk_data("full_data", exp_vec);
        chk("full_map", 128'(rd_map), {128{1'b1}});

        lanes = rnd_lanes(); lanes[0] = 8'h11;
        apply(1'b1, 1'b1, 0, 16'h0001, lanes);
        settle();
        chk("new_d1", 128'(rd_data[1]), 128'h11);
        chk("new_map_lo", 128'(rd_map[15:0]), 128'h0001);
`ifdef DAT_CHUNK_CLR_EN
        chk("new_d2_clr", 128'(rd_data[2]), 128'h00);
        chk("new_d128_clr", 128'(rd_data[128]), 128'h00);
        chk("new_map_hi_clr", 128'(rd_map[127:16]), '0);
`else
        chk("new_d2_keep", 128'(rd_data[2]), 128'h01);
        chk("new_d128_keep", 128'(rd_data[128]), 128'h7F);
        chk("new_map_hi_keep", 128'(rd_map[127:16]), 128'({112{1'b1}}));
`endif

        // Mid-chunk reset, then a fresh chunk must start filling at slot 1.
        for (int c = 0; c < 4; c++) apply(1'b1, 1'b1, c, rnd_map(), rnd_lanes());
        apply(1'b0, 1'b0, 0, '0, rnd_lanes());
        lanes = rnd_lanes(); lanes[1] = 8'h5A;
        apply(1'b1, 1'b1, 0, 16'h0002, lanes);
        settle();
        chk("rst_mid_d1", 128'(rd_data[1]), 128'h5A);
        x = 8'($urandom); lanes = rnd_lanes(); lanes[0] = x;
        apply(1'b1, 1'b1, 1, 16'h0001, lanes);
        settle();
        chk("rst_mid_d2", 128'(rd_data[2]), 128'(x));

        // Random in-order chunks with idle gaps and occasional mid-chunk resets.
        for (int ch = 0; ch < 40; ch++) begin
            for (int c = 0; c < 8; c++) begin
                repeat ($urandom_range(0, 2)) apply(1'b1, 1'b0, $urandom_range(0, 7), rnd_map(), rnd_lanes());
                if ($urandom_range(0, 49) == 0) apply(1'b0, $urandom_range(0, 1) == 1, c, rnd_map(), rnd_lanes());
                apply(1'b1, 1'b1, c, rnd_map(), rnd_lanes());
            end
        end

        apply(1'b1, 1'b0, 0, '0, '0);
        guard = 0;
        while (sb_q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #3;
        n_vec++;
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
